// File: rtl/half_adder_pkg.sv
// Shared widths and the response record for the half-adder arbiter slice.
package half_adder_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DATA_W     = 9;
  localparam int SUM_W      = DATA_W + 1;
  localparam int ID_W       = $clog2(NUM_REQ);
  localparam int FIFO_DEPTH = 4;

  // One queued result: originating requester plus the full-width sum.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [SUM_W-1:0] sum;
  } rsp_t;

endpackage

// File: rtl/half_adder_rsp_fifo.sv
// Synchronous result FIFO of rsp_t with occupancy count.
// Head is read straight from the storage registers; an empty FIFO shows zeros.
module half_adder_rsp_fifo
  import half_adder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  rsp_t          i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output rsp_t          o_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && !w_full;

  // Storage: data only, no reset needed since the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers and count; push and pop in the same cycle leave the count alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

  // The credit scheme upstream must never let a push hit a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule

// File: rtl/half_adder_arbiter.sv
// Round-robin front end sharing one external half_adder between requesters.
// Grants are credit-limited so every issued operation has a guaranteed FIFO
// slot; results come back tagged with the requester id, in issue order.
module half_adder_arbiter
  import half_adder_pkg::*;
#(
  parameter int NUM_REQ    = half_adder_pkg::NUM_REQ,
  parameter int DATA_W     = half_adder_pkg::DATA_W,
  parameter int FIFO_DEPTH = half_adder_pkg::FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [DATA_W:0]                 rsp_data,
  output logic                            add_in_valid,
  output logic [DATA_W-1:0]               add_data_in0,
  output logic [DATA_W-1:0]               add_data_in1,
  input  logic                            add_out_valid,
  input  logic [DATA_W:0]                 add_data_out,
  output logic                            add_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  // [1] = operands sitting in front of the adder, [2] = adder result expected.
  logic [2:1]        r_vld_pipe;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_s1_id;
  logic [IDW-1:0]    r_s2_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_err;

  logic [CW-1:0]      w_fifo_cnt;
  logic [CW:0]        w_used;
  logic               w_can_issue;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_gnt_id;
  logic               w_found;
  logic               w_xfer;
  logic               w_push;
  logic               w_pop;
  rsp_t               w_push_data;
  rsp_t               w_head;

  // Credit: queued plus in-flight results must leave room; pops do not count yet.
  assign w_used      = {1'b0, w_fifo_cnt} + (CW+1)'(r_vld_pipe[1]) + (CW+1)'(r_vld_pipe[2]);
  assign w_can_issue = (int'(w_used) < FIFO_DEPTH);

  // Round-robin search upward from the pointer; wrap comes free from IDW bits.
  always_comb begin
    logic [IDW-1:0] idx;
    idx      = '0;
    w_gnt    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = r_ptr + IDW'(i);
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_gnt_id = idx;
      end
    end
    if (w_found && w_can_issue && !rst) w_gnt[w_gnt_id] = 1'b1;
  end

  assign req_ready = w_gnt;
  assign w_xfer    = |w_gnt;

  // Stage 1 operand register and pointer advance; idle cycles drive zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_vld_pipe <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s1_id    <= '0;
      r_s2_id    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_xfer};
      r_a        <= w_xfer ? req_a[w_gnt_id] : '0;
      r_b        <= w_xfer ? req_b[w_gnt_id] : '0;
      r_s1_id    <= w_xfer ? w_gnt_id : '0;
      r_s2_id    <= r_s1_id;
      if (w_xfer) r_ptr <= w_gnt_id + 1'b1;
    end
  end

  assign add_in_valid = r_vld_pipe[1];
  assign add_data_in0 = r_a;
  assign add_data_in1 = r_b;

  // Only results the pipe expects are captured; strays and gaps flag an error.
  assign w_push          = r_vld_pipe[2] && add_out_valid;
  assign w_push_data.id  = r_s2_id;
  assign w_push_data.sum = add_data_out;

  // Sticky protocol error: adder valid disagrees with what was issued.
  always_ff @(posedge clk) begin
    if (rst)                                r_err <= 1'b0;
    else if (r_vld_pipe[2] != add_out_valid) r_err <= 1'b1;
  end

  assign add_err = r_err;
  assign w_pop   = rsp_valid && rsp_ready;

  half_adder_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (rsp_valid),
    .o_data  (w_head),
    .o_count (w_fifo_cnt)
  );

  assign rsp_id   = w_head.id;
  assign rsp_data = w_head.sum;

endmodule
